// File: rtl/cs_bus_pkg.sv
// Shared constants, state type and select-to-code mapping for the CPLD
// chip-select bus encoder.
package cs_bus_pkg;

  localparam logic [4:0] CS_CODE_RELEASE = 5'h00;
  localparam logic [4:0] CS_CODE_FLASH   = 5'h1D;
  localparam logic [4:0] CS_CODE_MAX3421 = 5'h1E;

  localparam logic [3:0] SEL_FLASH   = 4'd14;
  localparam logic [3:0] SEL_MAX3421 = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } cs_state_e;

  // Slot selects map to idx+1 so that code 0 stays reserved for release-all.
  function automatic logic [4:0] sel_to_code(input logic [3:0] sel);
    logic [4:0] code;
    case (sel)
      SEL_FLASH:   code = CS_CODE_FLASH;
      SEL_MAX3421: code = CS_CODE_MAX3421;
      default:     code = {1'b0, sel} + 5'd1;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cs_strobe_timer.sv
// Shared load / count-down / terminal-count timer for the SETUP, STROBE
// and HOLD phases. Loaded with (cycles-1); tc is high in the last cycle.
module cs_strobe_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/cs_bus_encoder.sv
// Initiator side of the CPLD chip-select bus: turns select requests into a
// cs code plus CS_READY strobe with setup/strobe/hold sequencing, and keeps
// a shadow of which selects the CPLD holds low.
// Optional build macro CS_EXCLUSIVE_EN: an assert while other selects are
// held first runs a release transaction, keeping the shadow single-hot.
//
// state  | meaning
// IDLE   | ready for a request, cs holds last code
// SETUP  | code stable on cs, CS_READY low
// STROBE | CS_READY high, shadow updated on entry
// HOLD   | CS_READY low, code still held
module cs_bus_encoder
  import cs_bus_pkg::*;
#(
  parameter int NUM_SLOTS       = 7,
  parameter int NUM_CS_PER_SLOT = 2,
  parameter int CS_IN_WIDTH     = 5,
  parameter int SETUP_CYCLES    = 2,
  parameter int STROBE_CYCLES   = 3,
  parameter int HOLD_CYCLES     = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_release,
  input  logic [3:0]             req_sel,
  output logic                   req_err,
  output logic [CS_IN_WIDTH-1:0] cs,
  output logic                   CS_READY,
  output logic [15:0]            cs_shadow
);

  localparam int MAX_SP  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int NUM_SEL = NUM_SLOTS * NUM_CS_PER_SLOT;

  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYCLES - 1);

  cs_state_e              state_q, state_d;
  logic [CS_IN_WIDTH-1:0] cs_q, cs_d;
  logic                   strobe_q, strobe_d;
  logic                   ready_q, ready_d;
  logic                   err_q, err_d;
  logic [15:0]            shadow_q, shadow_d;
  logic                   rel_q, rel_d;
  logic [3:0]             sel_q, sel_d;
`ifdef CS_EXCLUSIVE_EN
  logic                   pend_q, pend_d;
`endif

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_tc;
  logic             sel_valid;

  assign sel_valid = (int'(req_sel) < NUM_SEL) || (req_sel >= SEL_FLASH);

  cs_strobe_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Next-state and next-output logic for the select sequencer.
  always_comb begin
    state_d  = state_q;
    cs_d     = cs_q;
    strobe_d = strobe_q;
    ready_d  = ready_q;
    err_d    = 1'b0;
    shadow_d = shadow_q;
    rel_d    = rel_q;
    sel_d    = sel_q;
`ifdef CS_EXCLUSIVE_EN
    pend_d   = pend_q;
`endif
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (!req_release && !sel_valid) begin
            err_d = 1'b1;
          end else begin
            rel_d    = req_release;
            sel_d    = req_sel;
            cs_d     = req_release ? CS_IN_WIDTH'(CS_CODE_RELEASE)
                                   : CS_IN_WIDTH'(sel_to_code(req_sel));
            state_d  = ST_SETUP;
            ready_d  = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = LD_SETUP;
`ifdef CS_EXCLUSIVE_EN
            // Another select is held: drop everything first, assert afterwards.
            if (!req_release && ((shadow_q & ~(16'd1 << req_sel)) != 16'd0)) begin
              rel_d  = 1'b1;
              pend_d = 1'b1;
              cs_d   = CS_IN_WIDTH'(CS_CODE_RELEASE);
            end
`endif
          end
        end
      end
      ST_SETUP: begin
        if (tmr_tc) begin
          state_d  = ST_STROBE;
          strobe_d = 1'b1;
          shadow_d = rel_q ? 16'd0 : (shadow_q | (16'd1 << sel_q));
          tmr_load = 1'b1;
          tmr_val  = LD_STROBE;
        end
      end
      ST_STROBE: begin
        if (tmr_tc) begin
          state_d  = ST_HOLD;
          strobe_d = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_tc) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
`ifdef CS_EXCLUSIVE_EN
          if (pend_q) begin
            pend_d   = 1'b0;
            rel_d    = 1'b0;
            cs_d     = CS_IN_WIDTH'(sel_to_code(sel_q));
            state_d  = ST_SETUP;
            ready_d  = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = LD_SETUP;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cs_q     <= '0;
      strobe_q <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
      shadow_q <= 16'd0;
      rel_q    <= 1'b0;
      sel_q    <= 4'd0;
`ifdef CS_EXCLUSIVE_EN
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cs_q     <= cs_d;
      strobe_q <= strobe_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      rel_q    <= rel_d;
      sel_q    <= sel_d;
`ifdef CS_EXCLUSIVE_EN
      pend_q   <= pend_d;
`endif
    end
  end

  assign req_ready = ready_q;
  assign req_err   = err_q;
  assign cs        = cs_q;
  assign CS_READY  = strobe_q;
  assign cs_shadow = shadow_q;

endmodule

// File: tb/tb_cs_bus_encoder.sv
// Scoreboard bench for cs_bus_encoder (NUM_SLOTS=5 so that slot indices
// 10..13 are invalid). Honours CS_EXCLUSIVE_EN like the design.
module tb_cs_bus_encoder;

  localparam int NUM_SLOTS = 5;
  localparam int NCS       = 2;
  localparam int S         = 2;
  localparam int P         = 3;
  localparam int H         = 2;
  localparam int TXN       = S + P + H;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_release = 1'b0;
  logic [3:0]  req_sel = 4'd0;
  logic        req_ready;
  logic        req_err;
  logic [4:0]  cs;
  logic        CS_READY;
  logic [15:0] cs_shadow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [4:0]  code;
    logic [15:0] shadow;
  } exp_t;

  exp_t        strobe_q[$];
  bit          err_q[$];
  logic [15:0] m_shadow = 16'd0;
  logic [4:0]  m_last_code = 5'd0;
  bit          abort_flag = 1'b0;

  always #5 clk = ~clk;

  cs_bus_encoder #(
    .NUM_SLOTS       (NUM_SLOTS),
    .NUM_CS_PER_SLOT (NCS),
    .CS_IN_WIDTH     (5),
    .SETUP_CYCLES    (S),
    .STROBE_CYCLES   (P),
    .HOLD_CYCLES     (H)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_release (req_release),
    .req_sel     (req_sel),
    .req_err     (req_err),
    .cs          (cs),
    .CS_READY    (CS_READY),
    .cs_shadow   (cs_shadow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] code_of(input logic [3:0] sel);
    if (sel == 4'd14) return 5'h1D;
    if (sel == 4'd15) return 5'h1E;
    return 5'(int'(sel) + 1);
  endfunction

  // Reference model: what strobes (code, shadow after) a request should produce.
  task automatic predict(input logic rel, input logic [3:0] sel,
                         output int ntx, output logic [4:0] first_code);
    exp_t        e;
    logic [15:0] bitm;
    bit          need_rel;
    bitm     = 16'd1 << sel;
    need_rel = 1'b0;
    ntx        = 0;
    first_code = 5'd0;
    if (rel) begin
      e.code = 5'h00; e.shadow = 16'd0;
      strobe_q.push_back(e);
      m_shadow = 16'd0; m_last_code = 5'h00;
      ntx = 1;
    end else if (int'(sel) < NUM_SLOTS * NCS || int'(sel) >= 14) begin
`ifdef CS_EXCLUSIVE_EN
      need_rel = (m_shadow & ~bitm) != 16'd0;
`endif
      if (need_rel) begin
        e.code = 5'h00; e.shadow = 16'd0;
        strobe_q.push_back(e);
        m_shadow = 16'd0;
        ntx = 2; first_code = 5'h00;
      end else begin
        ntx = 1; first_code = code_of(sel);
      end
      m_shadow = m_shadow | bitm;
      e.code = code_of(sel); e.shadow = m_shadow;
      strobe_q.push_back(e);
      m_last_code = code_of(sel);
    end else begin
      err_q.push_back(1'b1);
    end
  endtask

  task automatic do_req(input logic rel, input logic [3:0] sel);
    int         ntx;
    logic [4:0] first_code;
    int         busy;
    int         first_rise;
    logic       prev;
    predict(rel, sel, ntx, first_code);
    @(negedge clk);
    check("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_release = rel; req_sel = sel;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_release = $urandom_range(0, 1);
    req_sel = 4'($urandom_range(0, 15));
    busy = 0; first_rise = -1; prev = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1 && ntx > 0) check("cs_at_t1", cs, first_code);
      if (CS_READY && !prev && first_rise < 0) first_rise = k;
      prev = CS_READY;
      if (req_ready) break;
      busy++;
    end
    check("busy_cycles", busy, ntx * TXN);
    if (ntx > 0) check("first_strobe_offset", first_rise, S + 1);
    check("shadow_after_req", cs_shadow, m_shadow);
    check("cs_idle_holds", cs, m_last_code);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    m_shadow = 16'd0; m_last_code = 5'd0;
    strobe_q.delete(); err_q.delete();
  endtask

  // Monitor: pops the scoreboard on every CS_READY rise and req_err pulse.
  initial begin : monitor
    logic       prev;
    int         width;
    logic [4:0] strobe_code;
    exp_t       e;
    prev = 1'b0; width = 0; strobe_code = 5'd0;
    forever begin
      @(negedge clk);
      if (req_err) begin
        check("err_expected", err_q.size() != 0, 1);
        if (err_q.size() != 0) void'(err_q.pop_front());
      end
      if (CS_READY && !prev) begin
        check("strobe_expected", strobe_q.size() != 0, 1);
        if (strobe_q.size() != 0) begin
          e = strobe_q.pop_front();
          check("strobe_code", cs, e.code);
          check("strobe_shadow", cs_shadow, e.shadow);
        end
        width = 1;
        strobe_code = cs;
      end else if (CS_READY) begin
        width++;
        check("cs_stable_in_strobe", cs, strobe_code);
      end else if (prev && !abort_flag) begin
        check("strobe_width", width, P);
        check("cs_first_hold", cs, strobe_code);
      end
      prev = CS_READY;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int         found;
    int         ntx;
    logic [4:0] fc;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check("rst_cs", cs, 0);
    check("rst_cs_ready", CS_READY, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_req_err", req_err, 0);
    check("rst_shadow", cs_shadow, 0);

    do_req(1'b0, 4'd3);
    do_req(1'b1, 4'd0);
    do_req(1'b0, 4'd14);
    do_req(1'b0, 4'd15);
    do_req(1'b0, 4'd11);
    do_req(1'b1, 4'd0);
    do_req(1'b0, 4'd0);
    do_req(1'b0, 4'd0);
    do_req(1'b0, 4'd5);
    do_req(1'b1, 4'd7);

    // Reset while the strobe is high.
    predict(1'b0, 4'd2, ntx, fc);
    @(negedge clk);
    req_valid = 1'b1; req_release = 1'b0; req_sel = 4'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (CS_READY) begin found = 1; break; end
    end
    check("reach_strobe", found, 1);
    abort_flag = 1'b1;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("abort_cs_ready", CS_READY, 0);
    check("abort_cs", cs, 0);
    check("abort_shadow", cs_shadow, 0);
    check("abort_req_ready", req_ready, 1);
    m_shadow = 16'd0; m_last_code = 5'd0;
    strobe_q.delete(); err_q.delete();
    repeat (3) @(negedge clk);
    abort_flag = 1'b0;

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 4) == 0) do_req(1'b1, 4'($urandom_range(0, 15)));
      else do_req(1'b0, 4'($urandom_range(0, 15)));
    end

    do_reset();
    check("final_reset_shadow", cs_shadow, 0);
    repeat (3) @(negedge clk);
    check("strobe_queue_drained", strobe_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
